// File: rtl/c1_pkg.sv
// Shared types for the C1 bus controller: zone/state enums, address-nibble
// constants and the zone-to-select helper.
package c1_pkg;

    typedef enum logic [3:0] {
        ZONE_NONE,
        ZONE_ROM,
        ZONE_WRAM,
        ZONE_PORT,
        ZONE_IO,
        ZONE_PAL,
        ZONE_CARD,
        ZONE_SROM,
        ZONE_SRAM
    } zone_e;

    typedef enum logic [1:0] {
        BS_IDLE,
        BS_ACTIVE,
        BS_DONE,
        BS_BERR
    } bus_state_e;

    // Byte-address bits [23:20] selecting each zone
    localparam logic [3:0] NIB_ROM     = 4'h0;
    localparam logic [3:0] NIB_WRAM    = 4'h1;
    localparam logic [3:0] NIB_PORT    = 4'h2;
    localparam logic [3:0] NIB_IO      = 4'h3;
    localparam logic [3:0] NIB_PAL     = 4'h4;
    localparam logic [3:0] NIB_CARD_LO = 4'h8;
    localparam logic [3:0] NIB_CARD_HI = 4'hB;
    localparam logic [3:0] NIB_SROM    = 4'hC;
    localparam logic [3:0] NIB_SRAM    = 4'hD;

    // Active-low select vector, bit order ROM,WRAM,PORT,IO,PAL,CARD,SROM,SRAM
    function automatic logic [7:0] zone_sel_n(zone_e z);
        logic [7:0] sel;
        sel = 8'hFF;
        case (z)
            ZONE_ROM:  sel[0] = 1'b0;
            ZONE_WRAM: sel[1] = 1'b0;
            ZONE_PORT: sel[2] = 1'b0;
            ZONE_IO:   sel[3] = 1'b0;
            ZONE_PAL:  sel[4] = 1'b0;
            ZONE_CARD: sel[5] = 1'b0;
            ZONE_SROM: sel[6] = 1'b0;
            ZONE_SRAM: sel[7] = 1'b0;
            default:   sel = 8'hFF;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/c1_zone_dec.sv
// Combinational address-nibble to zone decode; shared with the SRAM-lock logic.
module c1_zone_dec
    import c1_pkg::*;
(
    input  logic [3:0] nib_i,
    output zone_e      zone_o
);

    always_comb begin
        zone_o = ZONE_NONE;
        if (nib_i == NIB_ROM)
            zone_o = ZONE_ROM;
        else if (nib_i == NIB_WRAM)
            zone_o = ZONE_WRAM;
        else if (nib_i == NIB_PORT)
            zone_o = ZONE_PORT;
        else if (nib_i == NIB_IO)
            zone_o = ZONE_IO;
        else if (nib_i == NIB_PAL)
            zone_o = ZONE_PAL;
        else if (nib_i >= NIB_CARD_LO && nib_i <= NIB_CARD_HI)
            zone_o = ZONE_CARD;
        else if (nib_i == NIB_SROM)
            zone_o = ZONE_SROM;
        else if (nib_i == NIB_SRAM)
            zone_o = ZONE_SRAM;
    end

endmodule

// File: rtl/c1_bus_decode.sv
// C1 bus controller front end: latches the 68K cycle, drives zone selects and
// runs the DTACK timeout. Bus-error timeout is built only with C1_BERR_EN.
module c1_bus_decode
    import c1_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic        CLK_68KCLK,
    input  logic        RESET,
    input  logic [23:1] M68K_ADDR,
    input  logic        nAS,
    input  logic        M68K_RW,
    input  logic        nDTACK,
    output logic        nROM_ZONE,
    output logic        nWRAM_ZONE,
    output logic        nPORT_ZONE,
    output logic        nIO_ZONE,
    output logic        nPAL_ZONE,
    output logic        nCARD_ZONE,
    output logic        nSROM_ZONE,
    output logic        nSRAM_ZONE,
    output logic        nVALID,
    output logic        CYCLE_RW,
    output logic        nBERR
);

    zone_e      dec_zone;
    bus_state_e state_q;
    logic [7:0] nzone_q;
    logic       nvalid_q;
    logic       rw_q;
    logic       nberr_q;

    c1_zone_dec u_zone_dec (
        .nib_i  (M68K_ADDR[23:20]),
        .zone_o (dec_zone)
    );

`ifdef C1_BERR_EN
    logic [CNT_W-1:0] cnt_q;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT != CNT_W);
`endif

    always_ff @(posedge CLK_68KCLK) begin
        if (RESET) begin
            state_q  <= BS_IDLE;
            nzone_q  <= 8'hFF;
            nvalid_q <= 1'b1;
            rw_q     <= 1'b1;
            nberr_q  <= 1'b1;
`ifdef C1_BERR_EN
            cnt_q    <= '0;
`endif
        end else begin
            case (state_q)
                BS_IDLE: begin
                    if (!nAS) begin
                        nzone_q  <= zone_sel_n(dec_zone);
                        nvalid_q <= 1'b0;
                        rw_q     <= M68K_RW;
                        state_q  <= BS_ACTIVE;
`ifdef C1_BERR_EN
                        cnt_q    <= '0;
`endif
                    end
                end
                BS_ACTIVE: begin
                    if (nAS) begin
                        state_q  <= BS_IDLE;
                        nzone_q  <= 8'hFF;
                        nvalid_q <= 1'b1;
                        rw_q     <= 1'b1;
                    end else if (!nDTACK) begin
                        state_q  <= BS_DONE;
`ifdef C1_BERR_EN
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q  <= BS_BERR;
                        nberr_q  <= 1'b0;
                    end else if (cnt_q != '1) begin
                        cnt_q    <= cnt_q + 1'b1;
`endif
                    end
                end
                BS_DONE, BS_BERR: begin
                    // Both terminal states just wait for the strobe to drop
                    if (nAS) begin
                        state_q  <= BS_IDLE;
                        nzone_q  <= 8'hFF;
                        nvalid_q <= 1'b1;
                        rw_q     <= 1'b1;
                        nberr_q  <= 1'b1;
                    end
                end
                default: state_q <= BS_IDLE;
            endcase
        end
    end

    logic unused_addr;
    assign unused_addr = ^M68K_ADDR[19:1];

    assign {nSRAM_ZONE, nSROM_ZONE, nCARD_ZONE, nPAL_ZONE,
            nIO_ZONE, nPORT_ZONE, nWRAM_ZONE, nROM_ZONE} = nzone_q;
    assign nVALID   = nvalid_q;
    assign CYCLE_RW = rw_q;
    assign nBERR    = nberr_q;

endmodule

// File: tb/tb_c1_bus_decode.sv
// Directed self-checking bench for c1_bus_decode (timeout checks follow C1_BERR_EN).
module tb_c1_bus_decode;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        RESET;
    logic [23:1] M68K_ADDR;
    logic        nAS, M68K_RW, nDTACK;
    logic        nROM_ZONE, nWRAM_ZONE, nPORT_ZONE, nIO_ZONE, nPAL_ZONE;
    logic        nCARD_ZONE, nSROM_ZONE, nSRAM_ZONE, nVALID, CYCLE_RW, nBERR;
    logic [7:0]  zones;

    int checks = 0;
    int failures = 0;

    c1_bus_decode #(.TIMEOUT(TO), .CNT_W(4)) dut (
        .CLK_68KCLK (clk),
        .RESET      (RESET),
        .M68K_ADDR  (M68K_ADDR),
        .nAS        (nAS),
        .M68K_RW    (M68K_RW),
        .nDTACK     (nDTACK),
        .nROM_ZONE  (nROM_ZONE),
        .nWRAM_ZONE (nWRAM_ZONE),
        .nPORT_ZONE (nPORT_ZONE),
        .nIO_ZONE   (nIO_ZONE),
        .nPAL_ZONE  (nPAL_ZONE),
        .nCARD_ZONE (nCARD_ZONE),
        .nSROM_ZONE (nSROM_ZONE),
        .nSRAM_ZONE (nSRAM_ZONE),
        .nVALID     (nVALID),
        .CYCLE_RW   (CYCLE_RW),
        .nBERR      (nBERR)
    );

    always #5 clk = ~clk;

    assign zones = {nSRAM_ZONE, nSROM_ZONE, nCARD_ZONE, nPAL_ZONE,
                    nIO_ZONE, nPORT_ZONE, nWRAM_ZONE, nROM_ZONE};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [23:0] a);
        M68K_ADDR = a[23:1];
    endtask

    // Expected active-low zone vector per address nibble 0..F
    logic [7:0] exp_zone [16] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hFF, 8'hFF, 8'hFF,
                                  8'hDF, 8'hDF, 8'hDF, 8'hDF, 8'hBF, 8'h7F, 8'hFF, 8'hFF};

    initial begin
        RESET = 1'b1; nAS = 1'b1; M68K_RW = 1'b1; nDTACK = 1'b1;
        set_addr(24'h000000);
        tick();
        chk("rst_zones", zones, 8'hFF);
        chk("rst_nvalid", nVALID, 1);
        chk("rst_rw", CYCLE_RW, 1);
        chk("rst_nberr", nBERR, 1);
        RESET = 1'b0;
        tick();

        // Read of ROM, DTACK after 3 edges
        set_addr(24'h000100); M68K_RW = 1'b1; nAS = 1'b0;
        tick();
        chk("rd_zone", zones, 8'hFE);
        chk("rd_nvalid", nVALID, 0);
        chk("rd_rw", CYCLE_RW, 1);
        tick(); tick();
        chk("rd_wait_zone", zones, 8'hFE);
        nDTACK = 1'b0;
        tick();
        nDTACK = 1'b1;
        tick();
        chk("rd_done_zone", zones, 8'hFE);
        chk("rd_nberr", nBERR, 1);
        nAS = 1'b1;
        tick();
        chk("rd_rel_zone", zones, 8'hFF);
        chk("rd_rel_nvalid", nVALID, 1);

        // Write to SRAM, inputs toggled mid-cycle
        set_addr(24'hD00010); M68K_RW = 1'b0; nAS = 1'b0;
        tick();
        chk("wr_zone", zones, 8'h7F);
        chk("wr_rw", CYCLE_RW, 0);
        set_addr(24'h000000); M68K_RW = 1'b1;
        tick();
        chk("wr_frz_zone", zones, 8'h7F);
        chk("wr_frz_rw", CYCLE_RW, 0);
        nDTACK = 1'b0;
        tick();
        chk("wr_done_zone", zones, 8'h7F);
        nDTACK = 1'b1; nAS = 1'b1;
        tick();
        chk("wr_rel_zone", zones, 8'hFF);

        // Full decode table, back-to-back cycles with immediate DTACK
        for (int n = 0; n < 16; n++) begin
            set_addr({n[3:0], 20'h00000}); nAS = 1'b0;
            tick();
            chk($sformatf("tbl_zone_%0h", n), zones, exp_zone[n]);
            chk($sformatf("tbl_nvalid_%0h", n), nVALID, 0);
            nDTACK = 1'b0;
            tick();
            nDTACK = 1'b1; nAS = 1'b1;
            tick();
            chk($sformatf("tbl_rel_%0h", n), {zones, nVALID}, 9'h1FF);
        end

        // Unmapped access with no DTACK
        set_addr(24'h600000); nAS = 1'b0;
        tick();
        chk("um_zone", zones, 8'hFF);
        chk("um_nvalid", nVALID, 0);
        for (int i = 1; i < TO; i++) tick();
`ifdef C1_BERR_EN
        chk("um_pre_berr", nBERR, 1);
        tick();
        chk("um_berr", nBERR, 0);
        tick(); tick();
        chk("um_berr_hold", nBERR, 0);
        chk("um_berr_nvalid", nVALID, 0);
        chk("um_berr_zone", zones, 8'hFF);
`else
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("um_noberr", nBERR, 1);
        end
        chk("um_wait_nvalid", nVALID, 0);
`endif
        nAS = 1'b1;
        tick();
        chk("um_rel", {zones, nVALID, nBERR}, 10'h3FF);

        // DTACK on the same edge the timeout would fire
        set_addr(24'h100000); nAS = 1'b0;
        tick();
        chk("pri_zone", zones, 8'hFD);
        for (int i = 1; i < TO; i++) tick();
        nDTACK = 1'b0;
        tick();
        chk("pri_nberr", nBERR, 1);
        nDTACK = 1'b1;
        tick(); tick(); tick();
        chk("pri_done_nberr", nBERR, 1);
        chk("pri_done_zone", zones, 8'hFD);
        nAS = 1'b1;
        tick();

        // Reset in the middle of an IO cycle
        set_addr(24'h300000); nAS = 1'b0;
        tick();
        chk("rst_mid_zone", zones, 8'hF7);
        tick();
        RESET = 1'b1;
        tick();
        chk("rst_mid_out", {zones, nVALID, CYCLE_RW, nBERR}, 11'h7FF);
        RESET = 1'b0;
        tick();
        chk("rst_redec_zone", zones, 8'hF7);
        chk("rst_redec_nvalid", nVALID, 0);
        nAS = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
